// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control sequencer for the stopwatch.
//   Debounces the start/stop, lap and clear buttons. Runs the IDLE/RUN/LAP/STOP
//   state machine. Produces the count tick, the clear pulse and the lap-capture
//   strobe for the BCD counter and lap register, plus the display-mux select.
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   btn_start/btn_lap/btn_clr   raw buttons, asynchronous to clk
//   run                         counter advancing (RUN or LAP)
//   tick                        1-cycle count enable
//   clr                         1-cycle clear of counter and lap register
//   lap_load                    1-cycle lap capture strobe
//   show_lap                    display select (1 = held lap time)
//   state                       00 IDLE, 01 RUN, 10 LAP, 11 STOP
// Every output is registered.

// Per-button path: 2-flop synchroniser, stability counter, rising-edge pulse.
module stopwatch_ctrl_deb #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          deb_q, deb_prev_q, press_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], btn_i};
      deb_prev_q <= deb_q;
      // Registered edge detect: the pulse lands one cycle after deb rises.
      press_q    <= deb_q & ~deb_prev_q;
      if (sync_q[1] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        deb_q <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;
endmodule

module stopwatch_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int TICK_DIV   = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clr,
  output logic       run,
  output logic       tick,
  output logic       clr,
  output logic       lap_load,
  output logic       show_lap,
  output logic [1:0] state
);
  localparam int NUM_BTN = 3;
  localparam int DW      = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_LAP  = 2'b10,
    S_STOP = 2'b11
  } state_t;

  // Button index: 0 start, 1 lap, 2 clear.
  logic [NUM_BTN-1:0] btns, press;
  assign btns = {btn_clr, btn_lap, btn_start};

  stopwatch_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NUM_BTN-1:0] (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btns),
    .press_o(press)
  );

  logic ev_start, ev_lap, ev_clr;
  assign ev_start = press[0];
  assign ev_lap   = press[1];
  assign ev_clr   = press[2];

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          run_q, run_d, tick_q, tick_d, clr_q, clr_d;
  logic          lap_load_q, lap_load_d, show_lap_q, show_lap_d;
  logic          count_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      run_q      <= 1'b0;
      tick_q     <= 1'b0;
      clr_q      <= 1'b0;
      lap_load_q <= 1'b0;
      show_lap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      run_q      <= run_d;
      tick_q     <= tick_d;
      clr_q      <= clr_d;
      lap_load_q <= lap_load_d;
      show_lap_q <= show_lap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_d      = 1'b0;
    lap_load_d = 1'b0;
    // Priority clr > start > lap, but only among events the state accepts.
    unique case (state_q)
      S_IDLE: begin
        if (ev_clr)        clr_d   = 1'b1;
        else if (ev_start) state_d = S_RUN;
      end
      S_RUN: begin
        if (ev_start) state_d = S_STOP;
        else if (ev_lap) begin
          state_d    = S_LAP;
          lap_load_d = 1'b1;
        end
      end
      S_LAP: begin
        if (ev_clr)        state_d    = S_RUN;
        else if (ev_start) state_d    = S_STOP;
        else if (ev_lap)   lap_load_d = 1'b1;
      end
      S_STOP: begin
        if (ev_clr) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end else if (ev_start) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Counting freezes in the very cycle we head to STOP, so the partial
    // interval is kept for resume and no tick escapes on the stop edge.
    count_en = (state_q == S_RUN || state_q == S_LAP) && (state_d != S_STOP);
    tick_d   = count_en && (div_q == DIV_MAX);
    div_d    = div_q;
    if (count_en)
      div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
    else if (state_q == S_IDLE || state_d == S_IDLE)
      div_d = '0;

    run_d      = (state_d == S_RUN) || (state_d == S_LAP);
    show_lap_d = (state_d == S_LAP);
  end

  assign run      = run_q;
  assign tick     = tick_q;
  assign clr      = clr_q;
  assign lap_load = lap_load_q;
  assign show_lap = show_lap_q;
  assign state    = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;
  localparam int DEB = 4;
  localparam int TD  = 10;

  logic clk = 1'b0, rst = 1'b1;
  logic btn_start = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
  logic run, tick, clr, lap_load, show_lap;
  logic [1:0] state;

  stopwatch_ctrl #(.DEB_CYCLES(DEB), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .run(run), .tick(tick), .clr(clr), .lap_load(lap_load), .show_lap(show_lap), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_lap = 0, n_clr = 0, n_tick = 0;

  // Reference model: button levels accepted once DEB consecutive synchronised
  // samples disagree with the accepted level; an accepted rise reaches the
  // state machine two clocks later.
  logic [2:0]     m_s1, m_s2, m_deb, m_d1, m_d2;
  logic [DEB-1:0] m_hist [3];
  int             m_st, m_div;
  logic [6:0]     m_out; // {run,tick,clr,lap_load,show_lap,state}

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_d1 = '0; m_d2 = '0;
    for (int b = 0; b < 3; b++) m_hist[b] = '0;
    m_st = 0; m_div = 0; m_out = '0;
  endtask

  task automatic model_step();
    logic [2:0] raw, used, rise, ev;
    logic s, l, c, e_clr, e_lap, e_tick, counting;
    int nxt;
    raw = {btn_clr, btn_lap, btn_start};
    rise = '0;
    for (int b = 0; b < 3; b++) begin
      used[b] = m_s2[b];
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
      m_hist[b] = {m_hist[b][DEB-2:0], used[b]};
      if (m_hist[b] == {DEB{~m_deb[b]}}) begin
        rise[b]  = ~m_deb[b];
        m_deb[b] = ~m_deb[b];
      end
    end
    ev = m_d2; m_d2 = m_d1; m_d1 = rise;
    s = ev[0]; l = ev[1]; c = ev[2];
    nxt = m_st; e_clr = 0; e_lap = 0;
    if (m_st == 0) begin
      e_clr = c;
      if (!c && s) nxt = 1;
    end else if (m_st == 1) begin
      if (s) nxt = 3;
      else if (l) begin nxt = 2; e_lap = 1; end
    end else if (m_st == 2) begin
      if (c) nxt = 1;
      else if (s) nxt = 3;
      else e_lap = l;
    end else begin
      if (c) begin nxt = 0; e_clr = 1; end
      else if (s) nxt = 1;
    end
    counting = (m_st == 1 || m_st == 2) && nxt != 3;
    e_tick = counting && (m_div == TD - 1);
    if (counting) m_div = (m_div + 1) % TD;
    else if (m_st == 0 || nxt == 0) m_div = 0;
    m_st = nxt;
    m_out = {(nxt == 1 || nxt == 2), e_tick, e_clr, e_lap, (nxt == 2), 2'(nxt)};
  endtask

  function automatic logic [6:0] obs();
    return {run, tick, clr, lap_load, show_lap, state};
  endfunction

  task automatic chk(input string tag, input logic [6:0] o, input logic [6:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Advance n clocks, updating the model and checking every output each cycle.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      #1;
      chk("cycle", obs(), m_out);
      n_lap += int'(lap_load); n_clr += int'(clr); n_tick += int'(tick);
    end
  endtask

  task automatic press(input logic [2:0] m, input int hold, input int gap);
    {btn_clr, btn_lap, btn_start} = m;
    cyc(hold);
    {btn_clr, btn_lap, btn_start} = 3'b000;
    cyc(gap);
  endtask

  task automatic clr_cnts();
    n_lap = 0; n_clr = 0; n_tick = 0;
  endtask

  initial begin
    model_reset();
    cyc(3);
    chk("reset_outs", obs(), 7'b0);
    rst = 1'b0;
    cyc(2);

    // 1: held start -> one RUN entry exactly 8 clocks after first sampling edge
    btn_start = 1'b1;
    cyc(7);
    chk("t1_pre_run", {5'b0, state}, 7'b0);
    cyc(1);
    chk("t1_run", {run, 4'b0, state}, 7'b1000001);
    clr_cnts();
    cyc(12); btn_start = 1'b0; cyc(18);
    chk("t1_ticks", 7'(n_tick), 7'd3);
    chk("t1_state", {5'b0, state}, 7'b01);

    // 2: short lap glitch ignored, real lap press captures
    clr_cnts();
    press(3'b010, 3, 12);
    chk("t2_glitch_lap", 7'(n_lap), 7'd0);
    chk("t2_glitch_state", {5'b0, state}, 7'b01);
    clr_cnts();
    press(3'b010, 20, 12);
    chk("t2_lap_once", 7'(n_lap), 7'd1);
    chk("t2_lap_state", {4'b0, show_lap, state}, 7'b0000110);

    // 3: second lap stays in LAP; clr releases hold without a clr pulse
    clr_cnts();
    press(3'b010, 20, 12);
    chk("t3_lap2", {n_lap[2:0], 2'b0, state}, 7'b0010010);
    press(3'b100, 20, 12);
    chk("t3_clr_state", {show_lap, 4'b0, state}, 7'b0000001);
    chk("t3_no_clr", 7'(n_clr), 7'd0);

    // 4: stop/resume with divider preserved (model tracks tick phase)
    cyc(25);
    press(3'b001, 20, 12);
    clr_cnts();
    cyc(15);
    chk("t4_stop_noticks", {n_tick[4:0], state}, 7'b0000011);
    press(3'b001, 20, 12);
    chk("t4_resumed", {5'b0, state}, 7'b01);

    // 5: stop, then start+clr together -> clr wins; clr in RUN ignored
    press(3'b001, 20, 12);
    clr_cnts();
    press(3'b101, 20, 12);
    chk("t5_clr_wins", {n_clr[4:0], state}, 7'b0000100);
    press(3'b001, 20, 12);
    clr_cnts();
    press(3'b100, 20, 12);
    chk("t5_clr_in_run", {n_clr[4:0], state}, 7'b0000001);

    // 6: async reset from LAP with start held through release
    press(3'b010, 20, 12);
    chk("t6_in_lap", {5'b0, state}, 7'b10);
    rst = 1'b1; btn_start = 1'b1;
    #1;
    model_reset();
    chk("t6_async_rst", obs(), 7'b0);
    cyc(2);
    rst = 1'b0;
    clr_cnts();
    cyc(7);
    chk("t6_pre_run", {5'b0, state}, 7'b0);
    cyc(1);
    chk("t6_run", {5'b0, state}, 7'b01);
    chk("t6_no_pulses", {n_clr[2:0], n_lap[3:0]}, 7'b0);
    btn_start = 1'b0;
    cyc(12);

    // Randomised button traffic against the model
    for (int k = 0; k < 60; k++)
      press(3'($urandom_range(0, 7)), $urandom_range(1, 12), $urandom_range(1, 12));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
